// File: rtl/uart_apb_seq.sv
// uart_apb_seq: APB master that programs a 16550-style UART after reset and
// then feeds bytes from two round-robin requesters into the transmit holding
// register, polling LSR.THRE before each write.
module uart_apb_seq #(
  parameter logic [31:0] UART_BASE = 32'h0000_0000,
  parameter logic [15:0] DIVISOR   = 16'd27,
  parameter logic [7:0]  LCR_VAL   = 8'h03,
  parameter logic [7:0]  FCR_VAL   = 8'h07,
  parameter logic [7:0]  IER_VAL   = 8'h00,
  parameter int          POLL_GAP  = 4
) (
  input  logic        clock,
  input  logic        PRESETn,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic        tx0_valid,
  input  logic [7:0]  tx0_data,
  output logic        tx0_ready,
  input  logic        tx1_valid,
  input  logic [7:0]  tx1_data,
  output logic        tx1_ready,
  output logic        init_done,
  output logic        busy,
  output logic        err
);

  localparam logic [31:0] OFF_THR = 32'h00;
  localparam logic [31:0] OFF_IER = 32'h04;
  localparam logic [31:0] OFF_FCR = 32'h08;
  localparam logic [31:0] OFF_LCR = 32'h0C;
  localparam logic [31:0] OFF_LSR = 32'h14;
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    INIT_SETUP,
    INIT_ACCESS,
    IDLE,
    POLL_SETUP,
    POLL_ACCESS,
    POLL_WAIT,
    THR_SETUP,
    THR_ACCESS
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] gap_q, gap_d;
  logic        last_q, last_d;
  logic [7:0]  byte_q, byte_d;
  logic        init_done_q, init_done_d;
  logic        err_q, err_d;

  logic [31:0] init_off;
  logic [7:0]  init_byte;
  logic [31:0] apb_addr;
  logic [31:0] apb_wdata;
  logic        apb_write;
  logic        apb_sel;
  logic        apb_enable;
  logic        grant_ok;
  logic        hs0;
  logic        hs1;

  // Only THRE (bit 5) of the LSR matters; the other read bits are ignored.
  logic        unused_prdata;
  assign unused_prdata = ^{PRDATA[31:6], PRDATA[4:0]};

  // Configuration program: register offset and byte for each init step.
  // Step 0 sets DLAB so that steps 1 and 2 reach the divisor latch.
  always_comb begin
    init_off  = OFF_LCR;
    init_byte = 8'h80 | LCR_VAL;
    case (step_q)
      3'd0: begin init_off = OFF_LCR; init_byte = 8'h80 | LCR_VAL; end
      3'd1: begin init_off = OFF_THR; init_byte = DIVISOR[7:0];    end
      3'd2: begin init_off = OFF_IER; init_byte = DIVISOR[15:8];   end
      3'd3: begin init_off = OFF_LCR; init_byte = LCR_VAL;         end
      3'd4: begin init_off = OFF_FCR; init_byte = FCR_VAL;         end
      3'd5: begin init_off = OFF_IER; init_byte = IER_VAL;         end
      default: begin init_off = OFF_LCR; init_byte = 8'h80 | LCR_VAL; end
    endcase
  end

  // Round-robin arbiter: on a tie the requester that did not win last time
  // gets the grant; a lone requester always wins. Grants only in IDLE.
  always_comb begin
    grant_ok  = (state_q == IDLE) && init_done_q;
    tx0_ready = grant_ok && tx0_valid && (!tx1_valid || last_q);
    tx1_ready = grant_ok && tx1_valid && (!tx0_valid || !last_q);
    hs0       = tx0_valid && tx0_ready;
    hs1       = tx1_valid && tx1_ready;
  end

  // State register and all sequencing state; reset restarts the init program
  // and drops any byte already latched.
  always_ff @(posedge clock or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= INIT_SETUP;
      step_q      <= 3'd0;
      gap_q       <= 16'd0;
      last_q      <= 1'b1;
      byte_q      <= 8'h00;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      gap_q       <= gap_d;
      last_q      <= last_d;
      byte_q      <= byte_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: init writes, byte accept, LSR polling with back-off,
  // THR write. Every completing access folds PSLVERR into the sticky error.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    gap_d       = gap_q;
    last_d      = last_q;
    byte_d      = byte_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    case (state_q)
      INIT_SETUP: state_d = INIT_ACCESS;
      INIT_ACCESS: begin
        if (PREADY) begin
          err_d = err_q | PSLVERR;
          if (step_q == 3'd5) begin
            step_d      = 3'd0;
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = INIT_SETUP;
          end
        end
      end
      IDLE: begin
        if (hs0) begin
          byte_d  = tx0_data;
          last_d  = 1'b0;
          state_d = POLL_SETUP;
        end else if (hs1) begin
          byte_d  = tx1_data;
          last_d  = 1'b1;
          state_d = POLL_SETUP;
        end
      end
      POLL_SETUP: state_d = POLL_ACCESS;
      POLL_ACCESS: begin
        if (PREADY) begin
          err_d = err_q | PSLVERR;
          if (PRDATA[5] && !PSLVERR) begin
            state_d = THR_SETUP;
          end else begin
            gap_d   = 16'd0;
            state_d = POLL_WAIT;
          end
        end
      end
      POLL_WAIT: begin
        if (gap_q == GAP_LAST) begin
          state_d = POLL_SETUP;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      THR_SETUP: state_d = THR_ACCESS;
      THR_ACCESS: begin
        if (PREADY) begin
          err_d   = err_q | PSLVERR;
          state_d = IDLE;
        end
      end
      default: state_d = INIT_SETUP;
    endcase
  end

  // APB request decode from the current state; address, data and direction
  // are functions of state/step/latched byte so they hold through wait states.
  always_comb begin
    apb_addr   = 32'h0;
    apb_wdata  = 32'h0;
    apb_write  = 1'b0;
    apb_sel    = 1'b0;
    apb_enable = 1'b0;
    case (state_q)
      INIT_SETUP, INIT_ACCESS: begin
        apb_sel    = 1'b1;
        apb_enable = (state_q == INIT_ACCESS);
        apb_addr   = UART_BASE + init_off;
        apb_wdata  = {24'h0, init_byte};
        apb_write  = 1'b1;
      end
      POLL_SETUP, POLL_ACCESS: begin
        apb_sel    = 1'b1;
        apb_enable = (state_q == POLL_ACCESS);
        apb_addr   = UART_BASE + OFF_LSR;
      end
      THR_SETUP, THR_ACCESS: begin
        apb_sel    = 1'b1;
        apb_enable = (state_q == THR_ACCESS);
        apb_addr   = UART_BASE + OFF_THR;
        apb_wdata  = {24'h0, byte_q};
        apb_write  = 1'b1;
      end
      default: begin
        apb_sel = 1'b0;
      end
    endcase
  end

  // The reset state is INIT_SETUP, which would otherwise drive a setup phase,
  // so the bus outputs are forced quiet while PRESETn is low.
  assign PADDR     = PRESETn ? apb_addr  : 32'h0;
  assign PWDATA    = PRESETn ? apb_wdata : 32'h0;
  assign PWRITE    = PRESETn & apb_write;
  assign PSEL      = PRESETn & apb_sel;
  assign PENABLE   = PRESETn & apb_enable;
  assign init_done = init_done_q;
  assign err       = err_q;
  assign busy      = !((state_q == IDLE) && !tx0_valid && !tx1_valid);

endmodule

// File: tb/tb_uart_apb_seq.sv
// tb_uart_apb_seq: APB slave model plus byte requesters around uart_apb_seq,
// checked against a queue-based model of the init program and round-robin.
module tb_uart_apb_seq;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [15:0] DIV  = 16'd27;
  localparam logic [7:0]  LCRV = 8'h03;
  localparam logic [7:0]  FCRV = 8'h07;
  localparam logic [7:0]  IERV = 8'h00;
  localparam int          GAP  = 4;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    logic        wr;
    logic        post;
    int          cyc;
  } xact_t;

  logic        clock = 1'b0;
  logic        PRESETn = 1'b0;
  logic [31:0] PADDR, PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA = 32'h0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic        tx0_valid = 1'b0, tx1_valid = 1'b0;
  logic [7:0]  tx0_data = 8'h00, tx1_data = 8'h00;
  logic        tx0_ready, tx1_ready, init_done, busy, err;

  int checks = 0;
  int errors = 0;

  int    acc_idx = 0, waited = 0, wait_at_idx = -1, wait_n = 0, rand_need = 0;
  bit    rand_wait_en = 0, stall_thr = 0, err_on_thr = 0;
  logic [7:0] lsr_q[$];
  xact_t log_q[$];
  int    cyc = 0;

  logic [7:0] q0[$], q1[$];
  bit    h0 = 0, h1 = 0;
  int    rdy0_cnt = 0, rdy1_cnt = 0, early_rdy = 0;
  int    hs_cyc[$], hs_who[$];
  int    model_last = 1;

  uart_apb_seq #(
    .UART_BASE(BASE), .DIVISOR(DIV), .LCR_VAL(LCRV),
    .FCR_VAL(FCRV), .IER_VAL(IERV), .POLL_GAP(GAP)
  ) dut (
    .clock(clock), .PRESETn(PRESETn),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx0_valid(tx0_valid), .tx0_data(tx0_data), .tx0_ready(tx0_ready),
    .tx1_valid(tx1_valid), .tx1_data(tx1_data), .tx1_ready(tx1_ready),
    .init_done(init_done), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  // Slave response, decided mid-cycle: wait states, LSR values, error injection.
  // Also samples requester handshakes that will complete on the next edge.
  always @(negedge clock) begin
    int need;
    if (PRESETn && PSEL && PENABLE) begin
      if (stall_thr && PWRITE && PADDR == BASE && init_done) need = 1 << 30;
      else if (acc_idx == wait_at_idx) need = wait_n;
      else need = rand_need;
      if (waited < need) begin
        PREADY = 1'b0; PSLVERR = 1'b0; waited++;
      end else begin
        PREADY  = 1'b1;
        PSLVERR = err_on_thr && PWRITE && PADDR == BASE && init_done;
        PRDATA  = 32'h0;
        if (!PWRITE && PADDR == BASE + 32'h14) begin
          if (lsr_q.size() > 0) PRDATA = {24'h0, lsr_q.pop_front()};
          else PRDATA = 32'h60;
        end
      end
    end else begin
      PREADY = 1'b0; PSLVERR = 1'b0;
    end
    h0 = tx0_valid && tx0_ready;
    h1 = tx1_valid && tx1_ready;
    if (tx0_ready) rdy0_cnt++;
    if (tx1_ready) rdy1_cnt++;
    if ((tx0_ready || tx1_ready) && !init_done) early_rdy++;
  end

  // Transaction log of every completed APB access.
  always @(posedge clock) begin
    if (PRESETn && PSEL && PENABLE && PREADY) begin
      log_q.push_back('{PADDR, PWDATA[7:0], PWRITE, init_done, cyc});
      acc_idx++;
      waited = 0;
      rand_need = rand_wait_en ? int'($urandom_range(0, 2)) : 0;
    end
    cyc++;
  end

  // Requesters: present the head of each byte queue, pop on handshake.
  always @(posedge clock) begin
    #1;
    if (h0) begin void'(q0.pop_front()); hs_cyc.push_back(cyc); hs_who.push_back(0); end
    if (h1) begin void'(q1.pop_front()); hs_cyc.push_back(cyc); hs_who.push_back(1); end
    h0 = 0; h1 = 0;
    tx0_valid = (q0.size() != 0);
    tx0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
    tx1_valid = (q1.size() != 0);
    tx1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
  end

  task automatic do_reset;
    @(posedge clock); #1;
    PRESETn = 1'b0;
    #1;
    log_q.delete(); lsr_q.delete(); hs_cyc.delete(); hs_who.delete();
    acc_idx = 0; waited = 0; wait_at_idx = -1; wait_n = 0; rand_need = 0;
    stall_thr = 0; err_on_thr = 0; rand_wait_en = 0;
    rdy0_cnt = 0; rdy1_cnt = 0; early_rdy = 0; model_last = 1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic release_and_wait(output int n);
    PRESETn = 1'b1;
    n = 0;
    while (!init_done && n < 300) begin @(posedge clock); #1; n++; end
  endtask

  task automatic wait_quiet(output bit timeout);
    int k = 0;
    do begin
      @(posedge clock); #2; k++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !tx0_valid && !tx1_valid && !busy) && k < 4000);
    timeout = (k >= 4000);
  endtask

  function automatic void get_thr(input int start, output logic [7:0] d[$]);
    d.delete();
    for (int i = start; i < log_q.size(); i++)
      if (log_q[i].post && log_q[i].wr && log_q[i].addr == BASE) d.push_back(log_q[i].data);
  endfunction

  task automatic test_reset;
    do_reset();
    checks += 10;
    if (PSEL !== 1'b0)      begin errors++; $display("[TB] FAIL rst_psel: got %b want 0", PSEL); end
    if (PENABLE !== 1'b0)   begin errors++; $display("[TB] FAIL rst_penable: got %b want 0", PENABLE); end
    if (PADDR !== 32'h0)    begin errors++; $display("[TB] FAIL rst_paddr: got %h want 0", PADDR); end
    if (PWDATA !== 32'h0)   begin errors++; $display("[TB] FAIL rst_pwdata: got %h want 0", PWDATA); end
    if (PWRITE !== 1'b0)    begin errors++; $display("[TB] FAIL rst_pwrite: got %b want 0", PWRITE); end
    if (tx0_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_rdy0: got %b want 0", tx0_ready); end
    if (tx1_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_rdy1: got %b want 0", tx1_ready); end
    if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_init_done: got %b want 0", init_done); end
    if (busy !== 1'b1)      begin errors++; $display("[TB] FAIL rst_busy: got %b want 1", busy); end
    if (err !== 1'b0)       begin errors++; $display("[TB] FAIL rst_err: got %b want 0", err); end
  endtask

  task automatic test_init;
    logic [31:0] ea[6];
    logic [7:0]  ed[6];
    logic [7:0]  got[$];
    int n; bit to;
    ea = '{BASE + 32'h0C, BASE, BASE + 32'h04, BASE + 32'h0C, BASE + 32'h08, BASE + 32'h04};
    ed = '{8'h80 | LCRV, DIV[7:0], DIV[15:8], LCRV, FCRV, IERV};
    q0.push_back(8'h11);
    release_and_wait(n);
    checks++;
    if (n !== 12) begin errors++; $display("[TB] FAIL init_cycles: got %0d want 12", n); end
    checks++;
    if (log_q.size() !== 6) begin errors++; $display("[TB] FAIL init_count: got %0d want 6", log_q.size()); end
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].addr !== ea[i] || log_q[i].data !== ed[i] || log_q[i].wr !== 1'b1) begin
        errors++;
        $display("[TB] FAIL init_write%0d: got %h/%h/%b want %h/%h/1", i, log_q[i].addr, log_q[i].data, log_q[i].wr, ea[i], ed[i]);
      end
    end
    checks++;
    if (early_rdy !== 0) begin errors++; $display("[TB] FAIL ready_before_init: got %0d want 0", early_rdy); end
    wait_quiet(to);
    get_thr(0, got);
    checks++;
    if (to || got.size() !== 1 || got[0] !== 8'h11) begin
      errors++; $display("[TB] FAIL first_byte: got n=%0d timeout=%b", got.size(), to);
    end
    model_last = 0;
  endtask

  task automatic test_init_wait;
    int n = 0, held = 0, bad = 0;
    do_reset();
    wait_at_idx = 1; wait_n = 3;
    PRESETn = 1'b1;
    while (!init_done && n < 300) begin
      @(posedge clock); #1; n++;
      if (PSEL && PENABLE && acc_idx == 1) begin
        held++;
        if (PADDR !== BASE || PWDATA !== {24'h0, DIV[7:0]} || PWRITE !== 1'b1) bad++;
      end
    end
    checks += 3;
    if (n !== 15)   begin errors++; $display("[TB] FAIL wait_init_cycles: got %0d want 15", n); end
    if (held !== 4) begin errors++; $display("[TB] FAIL wait_access_cycles: got %0d want 4", held); end
    if (bad !== 0)  begin errors++; $display("[TB] FAIL wait_stable: got %0d unstable want 0", bad); end
    wait_at_idx = -1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] got[$];
    int start; bit to;
    start = log_q.size();
    rdy0_cnt = 0; rdy1_cnt = 0; hs_cyc.delete(); hs_who.delete();
    q0.push_back(8'hA5); q1.push_back(8'h3C);
    wait_quiet(to);
    get_thr(start, got);
    checks += 5;
    if (to || got.size() !== 2 || got[0] !== 8'hA5 || got[1] !== 8'h3C) begin
      errors++; $display("[TB] FAIL b2b_order: got n=%0d timeout=%b want A5,3C", got.size(), to);
    end
    if (rdy0_cnt !== 1) begin errors++; $display("[TB] FAIL b2b_rdy0: got %0d want 1", rdy0_cnt); end
    if (rdy1_cnt !== 1) begin errors++; $display("[TB] FAIL b2b_rdy1: got %0d want 1", rdy1_cnt); end
    if (hs_cyc.size() !== 2) begin errors++; $display("[TB] FAIL b2b_hs_count: got %0d want 2", hs_cyc.size()); end
    else if (hs_cyc[1] - hs_cyc[0] !== 5 || hs_who[0] !== 0) begin
      errors++; $display("[TB] FAIL b2b_spacing: got %0d first=%0d want 5 first=0", hs_cyc[1] - hs_cyc[0], hs_who[0]);
    end
    model_last = 1;
  endtask

  task automatic test_poll_retry;
    logic [7:0] got[$];
    int pc[$];
    int start; bit to;
    start = log_q.size();
    lsr_q.push_back(8'h00); lsr_q.push_back(8'h00); lsr_q.push_back(8'h20);
    q0.push_back(8'h5A);
    wait_quiet(to);
    for (int i = start; i < log_q.size(); i++)
      if (!log_q[i].wr && log_q[i].addr == BASE + 32'h14) pc.push_back(log_q[i].cyc);
    get_thr(start, got);
    checks += 2;
    if (to || pc.size() !== 3) begin errors++; $display("[TB] FAIL poll_count: got %0d want 3", pc.size()); end
    if (got.size() !== 1 || got[0] !== 8'h5A) begin errors++; $display("[TB] FAIL poll_thr: got n=%0d want 1 x 5A", got.size()); end
    for (int i = 1; i < pc.size(); i++) begin
      checks++;
      if (pc[i] - pc[i-1] !== GAP + 2) begin
        errors++; $display("[TB] FAIL poll_gap%0d: got %0d want %0d", i, pc[i] - pc[i-1], GAP + 2);
      end
    end
    model_last = 0;
  endtask

  task automatic test_slverr;
    logic [7:0] got[$];
    int start; bit to;
    start = log_q.size();
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_before: got %b want 0", err); end
    err_on_thr = 1;
    q1.push_back(8'h77);
    wait_quiet(to);
    checks++;
    if (to || err !== 1'b1) begin errors++; $display("[TB] FAIL err_set: got %b want 1", err); end
    err_on_thr = 0;
    q0.push_back(8'h88);
    wait_quiet(to);
    get_thr(start, got);
    checks += 2;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b want 1", err); end
    if (to || got.size() !== 2 || got[0] !== 8'h77 || got[1] !== 8'h88) begin
      errors++; $display("[TB] FAIL err_recover: got n=%0d timeout=%b want 77,88", got.size(), to);
    end
    model_last = 0;
  endtask

  task automatic test_random;
    logic [7:0] a0[$], a1[$], expq[$], got[$];
    int n0, n1, i0, i1, l, w, start; bit to;
    rand_wait_en = 1;
    for (int r = 0; r < 4; r++) begin
      a0.delete(); a1.delete(); expq.delete();
      n0 = $urandom_range(1, 4); n1 = $urandom_range(0, 4);
      for (int k = 0; k < n0; k++) a0.push_back(8'($urandom));
      for (int k = 0; k < n1; k++) a1.push_back(8'($urandom));
      i0 = 0; i1 = 0; l = model_last;
      while (i0 < n0 || i1 < n1) begin
        if (i0 < n0 && i1 < n1) w = (l == 1) ? 0 : 1;
        else w = (i0 < n0) ? 0 : 1;
        if (w == 0) begin expq.push_back(a0[i0]); i0++; end
        else begin expq.push_back(a1[i1]); i1++; end
        l = w;
      end
      model_last = l;
      for (int k = 0; k < n0 + n1; k++) begin
        repeat ($urandom_range(0, 2)) lsr_q.push_back(8'h00);
        lsr_q.push_back(($urandom_range(0, 1) == 1) ? 8'h60 : 8'h20);
      end
      start = log_q.size();
      foreach (a0[k]) q0.push_back(a0[k]);
      foreach (a1[k]) q1.push_back(a1[k]);
      wait_quiet(to);
      get_thr(start, got);
      checks++;
      if (to || got.size() !== expq.size()) begin
        errors++; $display("[TB] FAIL rand%0d_count: got %0d want %0d", r, got.size(), expq.size());
      end else begin
        for (int k = 0; k < expq.size(); k++) begin
          checks++;
          if (got[k] !== expq[k]) begin
            errors++; $display("[TB] FAIL rand%0d_byte%0d: got %h want %h", r, k, got[k], expq[k]);
          end
        end
      end
    end
    rand_wait_en = 0; rand_need = 0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] got[$];
    int k = 0, n;
    bit found = 0;
    stall_thr = 1;
    q1.push_back(8'hC3);
    while (!found && k < 300) begin
      @(posedge clock); #1; k++;
      if (PSEL && PENABLE && PWRITE && PADDR == BASE && init_done) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL mid_thr_access: got none want THR access"); end
    #2;
    PRESETn = 1'b0;
    #1;
    checks += 3;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_drop: got psel=%b penable=%b want 0/0", PSEL, PENABLE);
    end
    if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_init_done: got %b want 0", init_done); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy: got %b want 1", busy); end
    stall_thr = 0; log_q.delete(); acc_idx = 0; waited = 0; model_last = 1;
    q0.delete(); q1.delete();
    repeat (2) @(posedge clock);
    #1;
    release_and_wait(n);
    repeat (10) @(posedge clock);
    #1;
    get_thr(0, got);
    checks += 3;
    if (n !== 12) begin errors++; $display("[TB] FAIL mid_reinit_cycles: got %0d want 12", n); end
    if (log_q.size() == 0 || log_q[0].addr !== BASE + 32'h0C || log_q[0].data !== (8'h80 | LCRV)) begin
      errors++; $display("[TB] FAIL mid_restart: got n=%0d want first write 0C/83", log_q.size());
    end
    if (got.size() !== 0) begin errors++; $display("[TB] FAIL mid_byte_dropped: got %0d THR writes want 0", got.size()); end
  endtask

  initial begin
    $display("[TB] starting uart_apb_seq bench");
    test_reset();
    test_init();
    do_reset();
    test_init_wait();
    test_back_to_back();
    test_poll_retry();
    test_slverr();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_apb_seq.md
# uart_apb_seq

APB master controller that owns the UART register port. Out of reset it programs the UART with a fixed configuration: divisor latch, line control, FIFO control and interrupt enable. After that it shares the transmit holding register (THR) between two byte requesters using round-robin arbitration. Before each THR write it polls the line status register (LSR) for THRE. It sits between the SoC byte sources and the UART APB slave port.

## Interface
Parameters:
- UART_BASE, 32'h0000_0000, base address of the UART register block
- DIVISOR, 16'd27, baud divisor written to DLL (low byte) and DLM (high byte)
- LCR_VAL, 8'h03, final line control value (8N1); bit 7 must be 0
- FCR_VAL, 8'h07, FIFO control value
- IER_VAL, 8'h00, interrupt enable value
- POLL_GAP, 4, idle cycles between a failed LSR poll and the next poll (≥1)

Ports:
- clock  in  1  system clock, all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data; [7:0] carries the byte, [31:8] is always 0
- PWRITE  out  1  APB write enable
- PSEL  out  1  APB slave select
- PENABLE  out  1  APB access phase
- PRDATA  in  32  APB read data
- PREADY  in  1  APB slave ready
- PSLVERR  in  1  APB slave error
- tx0_valid / tx1_valid  in  1  requester byte valid
- tx0_data / tx1_data  in  8  requester byte
- tx0_ready / tx1_ready  out  1  requester accept
- init_done  out  1  configuration complete
- busy  out  1  any APB transfer pending or in flight
- err  out  1  sticky PSLVERR seen

## Operation
- Register offsets from UART_BASE: THR/DLL 0x00, IER/DLM 0x04, FCR 0x08, LCR 0x0C, LSR 0x14.
- Init program, all writes, in this order:
  - LCR = 8'h80 | LCR_VAL
  - DLL = DIVISOR[7:0]
  - DLM = DIVISOR[15:8]
  - LCR = LCR_VAL
  - FCR = FCR_VAL
  - IER = IER_VAL
- A 3-bit step counter indexes the init program.
- FSM states:
  - INIT_SETUP: setup phase for the current init step; next state INIT_ACCESS.
  - INIT_ACCESS: wait for PREADY. Then go to INIT_SETUP for the next step, or to IDLE after step 5, setting init_done.
  - IDLE: accept a byte from the arbiter winner. On a handshake, latch the byte and go to POLL_SETUP.
  - POLL_SETUP: setup phase of the LSR read; next state POLL_ACCESS.
  - POLL_ACCESS: wait for PREADY. If PRDATA[5] = 1 and PSLVERR = 0, go to THR_SETUP; otherwise go to POLL_WAIT.
  - POLL_WAIT: count POLL_GAP cycles, then go to POLL_SETUP.
  - THR_SETUP: setup phase of the THR write; next state THR_ACCESS.
  - THR_ACCESS: wait for PREADY, then go to IDLE.
- Arbitration, evaluated only in IDLE with init_done = 1:
  - The pointer `last` starts at 1, so requester 0 wins the first tie.
  - The winner is the valid requester other than `last`; if only one requester is valid, it wins.
  - txN_ready is combinational and high only for the winner in IDLE.
  - The handshake is txN_valid & txN_ready. `last` updates to the winner on that edge.
- A PSLVERR seen on any completing access sets err. err clears only on reset.
- An errored init write still advances to the next step.
- An errored LSR poll is treated as THRE = 0.

## Timing
- Reset values of outputs, applied asynchronously: PADDR = 0, PWDATA = 0, PWRITE = 0, PSEL = 0, PENABLE = 0, tx0_ready = 0, tx1_ready = 0, init_done = 0, busy = 1, err = 0.
- Internal reset state: FSM in INIT_SETUP, step = 0.
- APB signalling:
  - Setup phase: PSEL = 1, PENABLE = 0.
  - Access phase: PSEL = 1, PENABLE = 1, held until PREADY = 1.
  - PADDR, PWDATA and PWRITE are stable from setup until the access completes.
  - PSEL = 0 in IDLE and POLL_WAIT.
- Init with PREADY tied high takes 12 cycles. init_done rises on the 12th rising edge after PRESETn deasserts.
- Byte latency with THRE = 1 and zero wait states:
  - Handshake at edge t.
  - Poll setup in cycle t+1, poll access in t+2.
  - THR setup in t+3, THR access in t+4.
  - Back in IDLE at t+5, where the next handshake is possible.
- busy = 0 only in IDLE with both txN_valid low.
- A PRESETn assertion mid-transfer drops PSEL and PENABLE immediately. The latched byte is discarded and init restarts from step 0.
- The arbiter ignores requests while init_done = 0; both txN_ready stay 0.

## Test plan
- Init, DIVISOR = 27, PREADY = 1: writes in order (0x0C,0x83), (0x00,0x1B), (0x04,0x00), (0x0C,0x03), (0x08,0x07), (0x04,0x00) -> init_done = 1 after exactly 12 cycles.
- PREADY held low for 3 access cycles on step 1 -> PADDR = 0x00 and PWDATA = 0x1B stay stable for all 3 cycles, and init_done is delayed by 3 cycles.
- tx0_valid and tx1_valid both high with data 0xA5 and 0x3C, LSR = 0x60 -> THR writes 0xA5 then 0x3C; tx0_ready and tx1_ready each pulse once; handshakes are 5 cycles apart.
- LSR returns 0x00 twice, then 0x20 -> two retries, each preceded by POLL_GAP = 4 idle cycles; then one THR write.
- PSLVERR = 1 on the THR write -> err = 1 and stays 1; FSM returns to IDLE.
- PRESETn pulsed low during THR_ACCESS -> PSEL = 0 immediately; after release, the init sequence restarts from the LCR = 0x83 write.
